// File: rtl/spad_stream_loader_if.sv
// Valid/ready stream bundle used for the scratchpad load stream and the result output stream.
interface spad_stream_loader_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/spad_stream_loader.sv
// Host-side sequencer: streams words into the core's scratchpads, enables routing, then
// buffers ofmap results in a show-ahead FIFO and reports completion once it has drained.
module spad_stream_loader #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 8,
    parameter int NUM_SPADS   = 2,
    parameter int SEL_WIDTH   = 2,
    parameter int IFMAP_SPAD  = 1,
    parameter int OFMAP_WIDTH = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                            i_clk,
    input  logic                            i_nrst,
    input  logic                            i_start,
    input  logic                            i_abort,
    input  logic [NUM_SPADS*ADDR_WIDTH-1:0] i_len,
    spad_stream_loader_if.slave             in_stream,
    output logic                            o_write_en,
    output logic [ADDR_WIDTH-1:0]           o_write_addr,
    output logic [SEL_WIDTH-1:0]            o_spad_select,
    output logic [DATA_WIDTH-1:0]           o_data_out,
    output logic [ADDR_WIDTH-1:0]           o_i_addr_end,
    output logic                            o_route_en,
    input  logic [OFMAP_WIDTH-1:0]          i_ofmap,
    input  logic                            i_ofmap_valid,
    input  logic                            i_core_done,
    spad_stream_loader_if.master            out_stream,
    output logic                            o_overflow,
    output logic                            o_busy,
    output logic                            o_done
);
    localparam int IDX_W = $clog2(NUM_SPADS + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_SPADS);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOAD,
        S_GAP,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [NUM_SPADS*ADDR_WIDTH-1:0] len_q;
    logic [IDX_W-1:0]                idx;
    logic [ADDR_WIDTH-1:0]           word_cnt;
    logic [GAP_W-1:0]                gap_cnt;
    logic [ADDR_WIDTH-1:0]           cur_len;
    logic                            load_ready;
    logic                            beat;
    logic                            last_beat;

    logic [OFMAP_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]         wr_ptr, rd_ptr;
    logic                   fifo_empty, fifo_full;
    logic                   push_req, push_ok, pop;

    // Length of the spad currently selected; zero once every spad has been visited.
    always_comb begin
        cur_len = '0;
        for (int k = 0; k < NUM_SPADS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_len = len_q[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign load_ready      = (state == S_LOAD);
    assign in_stream.ready = load_ready;
    assign beat            = in_stream.valid && load_ready;
    assign last_beat       = beat && (word_cnt == cur_len - ADDR_WIDTH'(1));

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        o_route_en = 1'b0;
        o_done     = 1'b0;
        o_busy     = (state != S_IDLE);
        if (i_abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (i_start) state_next = S_SETUP;
                S_SETUP: begin
                    if (idx == IDX_END) begin
                        state_next = S_GAP;
                    end else if (cur_len != '0) begin
                        state_next = S_LOAD;
                    end
                end
                S_LOAD:  if (last_beat) state_next = S_SETUP;
                S_GAP:   if (gap_cnt == GAP_LAST) state_next = S_RUN;
                S_RUN:   if (i_core_done) state_next = S_DRAIN;
                S_DRAIN: if (fifo_empty) state_next = S_DONE;
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
        if (state == S_RUN) begin
            o_route_en = 1'b1;
        end
        if (state == S_DONE) begin
            o_done = 1'b1;
        end
    end

    // Write strobe lags the accepted beat by one cycle; address and data hold between beats.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            len_q         <= '0;
            idx           <= '0;
            word_cnt      <= '0;
            gap_cnt       <= '0;
            o_write_en    <= 1'b0;
            o_write_addr  <= '0;
            o_spad_select <= '0;
            o_data_out    <= '0;
            o_i_addr_end  <= '0;
        end else if (i_abort) begin
            o_write_en    <= 1'b0;
            o_write_addr  <= '0;
            o_spad_select <= '0;
            o_data_out    <= '0;
        end else begin
            o_write_en <= beat;
            if (beat) begin
                o_write_addr  <= word_cnt;
                o_spad_select <= SEL_WIDTH'(idx);
                o_data_out    <= in_stream.data;
                word_cnt      <= word_cnt + ADDR_WIDTH'(1);
                if (last_beat) begin
                    idx <= idx + IDX_W'(1);
                end
            end
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        len_q        <= i_len;
                        o_i_addr_end <= i_len[IFMAP_SPAD*ADDR_WIDTH +: ADDR_WIDTH] - ADDR_WIDTH'(1);
                        idx          <= '0;
                    end
                end
                S_SETUP: begin
                    if (idx == IDX_END) begin
                        gap_cnt <= '0;
                    end else if (cur_len == '0) begin
                        idx <= idx + IDX_W'(1);
                    end else begin
                        word_cnt <= '0;
                    end
                end
                S_GAP:   gap_cnt <= gap_cnt + GAP_W'(1);
                default: ;
            endcase
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push_req   = i_ofmap_valid && ((state == S_RUN) || (state == S_DRAIN));
    assign pop        = out_stream.valid && out_stream.ready;
    // A full FIFO still takes a result when the head leaves in the same cycle.
    assign push_ok    = push_req && (!fifo_full || pop);

    assign out_stream.valid = !fifo_empty;
    assign out_stream.data  = fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge i_clk) begin
        if (push_ok && !i_abort) begin
            mem[wr_ptr[PTR_W-1:0]] <= i_ofmap;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
        end else if (i_abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
            if ((state == S_IDLE) && i_start) begin
                o_overflow <= 1'b0;
            end else if (push_req && !push_ok) begin
                o_overflow <= 1'b1;
            end
        end
    end
endmodule
